// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency-measurement scheduler.
//   FREQ_W          : width of a measured frequency in Hz.
//   *_DEF           : default values for the scheduler parameters.
//   state_t         : scheduler FSM states.
//   cnt_w()         : bit width needed to hold the values 0..n-1 (at least 1).
package freq_meter_pkg;

  localparam int FREQ_W          = 34;
  localparam int NUM_CH_DEF      = 4;
  localparam int SETTLE_CYC_DEF  = 16;
  localparam int TIMEOUT_CYC_DEF = 100_000_000;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    START,
    WAIT,
    OUT
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/freq_meas_sched_rr_arbiter.sv
// Round-robin grant selection for the frequency-measurement scheduler.
// Purely combinational.
//   pending    in  NUM_CH          channels waiting for a measurement
//   last_grant in  clog2(NUM_CH)   most recently granted channel
//   grant_vld  out 1               at least one channel is pending
//   grant_idx  out clog2(NUM_CH)   first pending channel after last_grant,
//                                  searching upward and wrapping
module rr_arbiter
  import freq_meter_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  logic [NUM_CH-1:0]         pending,
  input  logic [$clog2(NUM_CH)-1:0] last_grant,
  output logic                      grant_vld,
  output logic [$clog2(NUM_CH)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_CH);

  logic [IDX_W-1:0] idx;
  int               sum;

  // Walk the candidates from farthest to nearest so the nearest pending
  // channel after last_grant is the one that sticks.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    sum       = 0;
    for (int i = NUM_CH; i >= 1; i--) begin
      sum = int'(last_grant) + i;
      if (sum >= NUM_CH) begin
        sum = sum - NUM_CH;
      end
      idx = IDX_W'(sum);
      if (pending[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/freq_meas_sched.sv
// Frequency-measurement scheduler.
// Steers an external test-clock mux to one channel at a time, lets the mux
// settle, starts one meter gate window and hands the result (or a timeout
// error) to a valid/ready consumer. Channels are served round-robin from
// pending requests; with auto_en set and nothing pending it scans all
// channels in turn.
// Ports:
//   sys_clk     in   system clock, rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   req         in   per-channel request pulses
//   auto_en     in   continuous scan when nothing is pending
//   chan_sel    out  test-clock mux select
//   meas_start  out  one-cycle meter start pulse
//   meas_done   in   one-cycle meter completion pulse
//   meas_freq   in   meter result, valid with meas_done
//   res_valid   out  result available, held until accepted
//   res_ready   in   consumer accepts the result
//   res_chan    out  channel of the result
//   res_freq    out  result frequency in Hz, 0 on timeout
//   res_err     out  measurement timed out
//   busy        out  FSM is not idle
module freq_meas_sched
  import freq_meter_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [NUM_CH-1:0]         req,
  input  logic                      auto_en,
  output logic [$clog2(NUM_CH)-1:0] chan_sel,
  output logic                      meas_start,
  input  logic                      meas_done,
  input  logic [FREQ_W-1:0]         meas_freq,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(NUM_CH)-1:0] res_chan,
  output logic [FREQ_W-1:0]         res_freq,
  output logic                      res_err,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int SET_W = cnt_w(SETTLE_CYC);
  localparam int TMO_W = cnt_w(TIMEOUT_CYC);

  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);
  localparam logic [SET_W-1:0] SET_END = SET_W'(SETTLE_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_END = TMO_W'(TIMEOUT_CYC - 1);

  state_t             state_q,      state_d;
  logic [NUM_CH-1:0]  pending_q,    pending_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   chan_sel_q,   chan_sel_d;
  logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q,    tmo_cnt_d;
  logic [IDX_W-1:0]   res_chan_q,   res_chan_d;
  logic [FREQ_W-1:0]  res_freq_q,   res_freq_d;
  logic               res_err_q,    res_err_d;

  logic               arb_vld;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   next_auto;
  logic [IDX_W-1:0]   gidx;
  logic [NUM_CH-1:0]  clr;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .pending    (pending_q),
    .last_grant (last_grant_q),
    .grant_vld  (arb_vld),
    .grant_idx  (arb_idx)
  );

  assign next_auto = (last_grant_q == LAST_CH) ? '0 : last_grant_q + IDX_W'(1);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    chan_sel_d   = chan_sel_q;
    settle_cnt_d = settle_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    res_chan_d   = res_chan_q;
    res_freq_d   = res_freq_q;
    res_err_d    = res_err_q;
    gidx         = '0;
    clr          = '0;

    case (state_q)
      IDLE: begin
        // A real request always beats the auto scan.
        if (arb_vld || auto_en) begin
          gidx         = arb_vld ? arb_idx : next_auto;
          chan_sel_d   = gidx;
          last_grant_d = gidx;
          clr[gidx]    = 1'b1;
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == SET_END) begin
          settle_cnt_d = '0;
          state_d      = START;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end
      START: begin
        tmo_cnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        // meas_done is checked first so a result arriving on the timeout
        // cycle is still reported as a good measurement.
        if (meas_done) begin
          res_chan_d = chan_sel_q;
          res_freq_d = meas_freq;
          res_err_d  = 1'b0;
          tmo_cnt_d  = '0;
          state_d    = OUT;
        end else if (tmo_cnt_q == TMO_END) begin
          res_chan_d = chan_sel_q;
          res_freq_d = '0;
          res_err_d  = 1'b1;
          tmo_cnt_d  = '0;
          state_d    = OUT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      OUT: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // OR-ing req after the clear lets a new request for the channel being
    // granted survive, so that channel is measured again later.
    pending_d = (pending_q & ~clr) | req;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      last_grant_q <= LAST_CH;
      chan_sel_q   <= '0;
      settle_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      res_chan_q   <= '0;
      res_freq_q   <= '0;
      res_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      chan_sel_q   <= chan_sel_d;
      settle_cnt_q <= settle_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      res_chan_q   <= res_chan_d;
      res_freq_q   <= res_freq_d;
      res_err_q    <= res_err_d;
    end
  end

  // Status outputs decode straight from the state so reset clears them at once.
  assign chan_sel   = chan_sel_q;
  assign meas_start = (state_q == START);
  assign res_valid  = (state_q == OUT);
  assign busy       = (state_q != IDLE);
  assign res_chan   = res_chan_q;
  assign res_freq   = res_freq_q;
  assign res_err    = res_err_q;

endmodule

// File: tb/tb_freq_meas_sched.sv
// Self-checking bench for freq_meas_sched (NUM_CH=4, SETTLE_CYC=4,
// TIMEOUT_CYC=50). Stimulus pushes expected grants and results into queues;
// a monitor pops and compares whenever the DUT grants or hands off a result.
module tb_freq_meas_sched;
  import freq_meter_pkg::*;

  localparam int NCH  = 4;
  localparam int SCYC = 4;
  localparam int TCYC = 50;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic [NCH-1:0]    req = '0;
  logic              auto_en = 1'b0;
  logic [1:0]        chan_sel;
  logic              meas_start;
  logic              meas_done;
  logic [FREQ_W-1:0] meas_freq;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [1:0]        res_chan;
  logic [FREQ_W-1:0] res_freq;
  logic              res_err;
  logic              busy;

  freq_meas_sched #(
    .NUM_CH      (NCH),
    .SETTLE_CYC  (SCYC),
    .TIMEOUT_CYC (TCYC)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req        (req),
    .auto_en    (auto_en),
    .chan_sel   (chan_sel),
    .meas_start (meas_start),
    .meas_done  (meas_done),
    .meas_freq  (meas_freq),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_chan   (res_chan),
    .res_freq   (res_freq),
    .res_err    (res_err),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [1:0]        chan;
    logic [FREQ_W-1:0] freq;
    logic              err;
  } res_t;

  res_t       exp_res[$];
  logic [1:0] exp_grant[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Meter model: answers meter_dly cycles after it samples meas_start.
  logic [FREQ_W-1:0] freq_tab[NCH];
  logic              meter_on  = 1'b1;
  int                meter_dly = 20;
  int                cd        = 0;
  logic              armed     = 1'b0;

  initial begin
    meas_done = 1'b0;
    meas_freq = '0;
    forever begin
      @(negedge sys_clk);
      meas_done = 1'b0;
      if (armed) begin
        cd--;
        if (cd == 0) begin
          armed     = 1'b0;
          meas_done = 1'b1;
          meas_freq = freq_tab[chan_sel];
        end
      end
      if (meas_start && meter_on) begin
        armed = 1'b1;
        cd    = meter_dly;
      end
    end
  end

  // Monitor / scoreboard.
  logic busy_prev = 1'b0;
  logic rv_prev   = 1'b0;
  logic stable    = 1'b1;
  logic chan_moved = 1'b0;
  logic [1:0] chan_prev = '0;
  res_t held;
  res_t cur;
  res_t e_m;
  int grant_cyc = 0, start_cyc = 0, rv_cyc = 0, hs_cyc = 0;
  int valid_len = 0, last_len = 0, res_cnt = 0;

  initial begin
    forever begin
      @(negedge sys_clk);
      cur = {res_chan, res_freq, res_err};
      if (busy && !busy_prev) begin
        grant_cyc  = cyc;
        chan_moved = 1'b0;
        if (exp_grant.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL grant_unexpected: got chan %0d, required no grant", chan_sel);
        end else begin
          chk("grant_chan", chan_sel, exp_grant.pop_front());
        end
      end else if (busy && busy_prev && chan_sel != chan_prev) begin
        chan_moved = 1'b1;
      end
      if (meas_start) start_cyc = cyc;
      if (res_valid && !rv_prev) begin
        rv_cyc    = cyc;
        held      = cur;
        stable    = 1'b1;
        valid_len = 0;
      end
      if (res_valid) begin
        valid_len++;
        if (cur != held) stable = 1'b0;
      end
      if (res_valid && res_ready) begin
        hs_cyc   = cyc;
        last_len = valid_len;
        res_cnt++;
        chk("res_stable", stable, 1);
        chk("chan_sel_stable", chan_moved, 0);
        if (exp_res.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL res_unexpected: got chan %0d freq %0d err %0d, required no result",
                   res_chan, res_freq, res_err);
        end else begin
          e_m = exp_res.pop_front();
          chk("res_chan", res_chan, e_m.chan);
          chk("res_freq", res_freq, e_m.freq);
          chk("res_err", res_err, e_m.err);
        end
      end
      busy_prev = busy;
      rv_prev   = res_valid;
      chan_prev = chan_sel;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    req       = '0;
    auto_en   = 1'b0;
    res_ready = 1'b1;
    meter_on  = 1'b1;
    tick(3);
    sys_rst_n = 1'b1;
    tick(1);
  endtask

  task automatic pulse_req(input logic [NCH-1:0] r);
    req = r;
    tick(1);
    req = '0;
  endtask

  task automatic exp_ok(input logic [1:0] ch);
    exp_grant.push_back(ch);
    exp_res.push_back('{chan: ch, freq: freq_tab[ch], err: 1'b0});
  endtask

  task automatic wait_idle(input string name, input int maxc);
    logic done;
    done = 1'b0;
    for (int k = 0; k < maxc && !done; k++) begin
      @(negedge sys_clk);
      if (exp_res.size() == 0 && exp_grant.size() == 0 && !busy) done = 1'b1;
    end
    chk(name, done, 1);
    tick(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_chan_sel"}, chan_sel, 0);
    chk({tag, "_meas_start"}, meas_start, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_chan"}, res_chan, 0);
    chk({tag, "_res_freq"}, res_freq, 0);
    chk({tag, "_res_err"}, res_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  int   r0, h, len;
  logic got;

  initial begin
    freq_tab[0] = 34'd1_000_000;
    freq_tab[1] = 34'd25_000_000;
    freq_tab[2] = 34'd12_345_678;
    freq_tab[3] = 34'h3_FFFF_FFFF;

    // Reset state, then idle with auto_en=0 and nothing pending.
    tick(2);
    check_reset_outputs("rst");
    sys_rst_n = 1'b1;
    tick(20);
    chk("idle_no_auto_busy", busy, 0);
    chk("idle_no_auto_results", res_cnt, 0);

    // Single request on channel 2, meter answers 20 cycles after start.
    do_reset();
    meter_dly = 20;
    exp_grant.push_back(2'd2);
    exp_res.push_back('{chan: 2'd2, freq: 34'd12_345_678, err: 1'b0});
    r0 = res_cnt;
    pulse_req(4'b0100);
    wait_idle("t1_done", 200);
    chk("t1_start_latency", start_cyc + 1 - grant_cyc, SCYC + 1);
    chk("t1_result_latency", rv_cyc - (start_cyc + 1), 20);
    chk("t1_num_results", res_cnt - r0, 1);
    chk("t1_accept_first_out_cycle", last_len, 1);

    // Round-robin from reset: 0, 1, 3.
    do_reset();
    meter_dly = 5;
    exp_ok(2'd0);
    exp_ok(2'd1);
    exp_ok(2'd3);
    r0 = res_cnt;
    pulse_req(4'b1011);
    wait_idle("t2_done", 300);
    chk("t2_num_results", res_cnt - r0, 3);

    // Timeout: the meter never answers.
    do_reset();
    meter_on = 1'b0;
    exp_grant.push_back(2'd1);
    exp_res.push_back('{chan: 2'd1, freq: '0, err: 1'b1});
    pulse_req(4'b0010);
    wait_idle("t3_done", 300);
    chk("t3_timeout_latency", rv_cyc - (start_cyc + 1), TCYC);

    // Backpressure: consumer stalls 30 cycles; channel 2 waits for the handshake.
    do_reset();
    meter_dly = 5;
    res_ready = 1'b0;
    exp_ok(2'd0);
    exp_ok(2'd2);
    pulse_req(4'b0101);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge sys_clk);
      if (res_valid) got = 1'b1;
    end
    chk("t4_valid_seen", got, 1);
    tick(30);
    res_ready = 1'b1;
    @(negedge sys_clk);
    #1;
    h   = hs_cyc;
    len = last_len;
    chk("t4_valid_held_cycles", len, 31);
    wait_idle("t4_done", 300);
    chk("t4_next_grant_after_handshake", grant_cyc - h, 2);

    // Auto scan 0,1,2,3,0; req[2] during channel 0's WAIT jumps ahead of 1.
    do_reset();
    meter_dly = 10;
    exp_ok(2'd0);
    exp_ok(2'd1);
    exp_ok(2'd2);
    exp_ok(2'd3);
    exp_ok(2'd0);
    exp_ok(2'd2);
    exp_ok(2'd3);
    r0 = res_cnt;
    auto_en = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 1000 && !got; k++) begin
      @(negedge sys_clk);
      if (exp_grant.size() == 2 && meas_start) got = 1'b1;
    end
    chk("t5_fifth_start_seen", got, 1);
    tick(1);
    pulse_req(4'b0100);
    got = 1'b0;
    for (int k = 0; k < 1000 && !got; k++) begin
      @(negedge sys_clk);
      if (exp_grant.size() == 0) got = 1'b1;
    end
    chk("t5_seventh_grant_seen", got, 1);
    tick(1);
    auto_en = 1'b0;
    wait_idle("t5_done", 300);
    chk("t5_num_results", res_cnt - r0, 7);

    // Reset during WAIT: outputs clear at once, late meas_done is ignored.
    do_reset();
    meter_dly = 20;
    exp_grant.push_back(2'd1);
    pulse_req(4'b0010);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge sys_clk);
      if (meas_start) got = 1'b1;
    end
    chk("t6_start_seen", got, 1);
    tick(5);
    chk("t6_busy_before_reset", busy, 1);
    sys_rst_n = 1'b0;
    #1;
    check_reset_outputs("t6");
    tick(2);
    sys_rst_n = 1'b1;
    r0 = res_cnt;
    tick(40);
    chk("t6_no_result_after_reset", res_cnt - r0, 0);
    chk("t6_idle_after_reset", busy, 0);
    chk("t6_grants_drained", exp_grant.size(), 0);
    chk("final_results_drained", exp_res.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/freq_meas_sched.md
FREQ_MEAS_SCHED -- requirements
Module: freq_meas_sched

Interface
REQ-001 Parameter NUM_CH, default 4: number of test-clock channels, 2..8.
REQ-002 Parameter SETTLE_CYC, default 16: sys_clk cycles to wait after a mux change before starting a measurement, at least 1.
REQ-003 Parameter TIMEOUT_CYC, default 100_000_000: sys_clk cycles to wait for meas_done before declaring an error; this is 2 s at 50 MHz.
REQ-004 sys_clk  in  1  system clock; all logic is on its rising edge.
REQ-005 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req  in  NUM_CH  per-channel measurement request; a one-cycle pulse is sufficient.
REQ-007 auto_en  in  1  when 1, the block scans all channels continuously while no request is pending.
REQ-008 chan_sel  out  clog2(NUM_CH)  select for the external test-clock mux feeding the meter.
REQ-009 meas_start  out  1  one-cycle pulse that starts one meter gate window.
REQ-010 meas_done  in  1  one-cycle pulse from the meter; meas_freq is valid in the same cycle.
REQ-011 meas_freq  in  34  measured frequency in Hz.
REQ-012 res_valid  out  1  result available; held until accepted.
REQ-013 res_ready  in  1  consumer accepts the result.
REQ-014 res_chan  out  clog2(NUM_CH)  channel the result belongs to.
REQ-015 res_freq  out  34  result frequency; 0 on error.
REQ-016 res_err  out  1  1 means the measurement timed out.
REQ-017 busy  out  1  1 whenever the FSM is not in IDLE.

Function
REQ-018 A req[i] pulse shall set pending[i]; the bit stays set until channel i is granted.
- If a set and a grant-clear of the same bit occur in the same cycle, the set wins.
REQ-019 Grants shall be round-robin. The search starts at last_grant+1 and wraps modulo NUM_CH.
REQ-020 When pending is all-zero and auto_en=1, the grant shall be (last_grant+1) mod NUM_CH.
REQ-021 FSM states and transitions:
- IDLE: if a grant exists, load chan_sel, clear the granted pending bit, update last_grant, go to SETTLE.
- SETTLE: count SETTLE_CYC cycles, then go to START.
- START: assert meas_start for one cycle, clear the timeout counter, go to WAIT.
- WAIT: on meas_done, go to OUT; when the timeout counter reaches TIMEOUT_CYC-1 without meas_done, go to OUT with an error.
- OUT: hold res_valid=1; when res_ready=1, go to IDLE.
REQ-022 In WAIT, meas_done shall load res_freq=meas_freq and res_err=0.
REQ-023 On timeout, res_freq shall be 0 and res_err=1.
REQ-024 If meas_done and the timeout occur in the same cycle, meas_done wins.
REQ-025 meas_done outside WAIT shall be ignored.
REQ-026 res_chan, res_freq and res_err shall be stable while res_valid=1.
REQ-027 res_valid shall fall in the cycle after the handshake (res_valid and res_ready both 1).
REQ-028 If res_ready is already 1 when OUT is entered, the result shall be accepted in that first OUT cycle.
REQ-029 Latency from the IDLE grant edge to meas_start=1 shall be exactly SETTLE_CYC+1 cycles.
REQ-030 chan_sel shall change only on the IDLE grant edge; it shall never change during SETTLE, START, WAIT or OUT.
REQ-031 A request for the channel currently in progress shall re-set its pending bit, and the channel shall be measured again later.
REQ-032 With auto_en=0 and no pending request, the FSM shall remain in IDLE.

Reset
REQ-033 On sys_rst_n=0 the block shall reset immediately to:
- FSM = IDLE, pending = 0, last_grant = NUM_CH-1, chan_sel = 0;
- meas_start = 0, res_valid = 0, res_chan = 0, res_freq = 0, res_err = 0, busy = 0;
- all counters = 0.
REQ-034 A reset in the middle of a measurement shall discard the measurement; no res_valid shall be produced for it.
REQ-035 The first grant after reset shall be channel 0.

Structure
REQ-036 The shared package freq_meter_pkg shall hold:
- the FSM state typedef (IDLE, SETTLE, START, WAIT, OUT);
- FREQ_W=34;
- the defaults for NUM_CH, SETTLE_CYC and TIMEOUT_CYC.
REQ-037 The round-robin grant logic shall be one sub-module, rr_arbiter.
- Inputs: pending, last_grant.
- Outputs: grant_vld, grant_idx.

Verification (bench parameters: NUM_CH=4, SETTLE_CYC=4, TIMEOUT_CYC=50)
REQ-038 Single request: req=4'b0100 pulse, meter returns 12_345_678 20 cycles after meas_start, res_ready=1 -> chan_sel=2; meas_start 5 cycles after the grant; one result with res_chan=2, res_freq=12_345_678, res_err=0.
REQ-039 Round-robin: req=4'b1011 in one cycle, res_ready=1 -> grant order 0, 1, 3; exactly three results.
REQ-040 Timeout: meas_done never asserted -> res_valid with res_err=1 and res_freq=0, 50 cycles after meas_start.
REQ-041 Backpressure: res_ready=0 for 30 cycles, then 1 -> res_valid and all result fields stable for 30 cycles; the next grant occurs only after the handshake.
REQ-042 Auto scan: auto_en=1, no req, res_ready=1, meter always answers -> chan_sel sequence 0, 1, 2, 3, 0; a req[2] pulse arriving while channel 0 is in WAIT is served next, ahead of channel 1.
REQ-043 Reset during WAIT: sys_rst_n asserted -> all outputs return to reset values at once; a late meas_done after reset produces no result.
